rf_scoreboard: RTL and testbench
================================

Name: rf_scoreboard

Overview:
- Tracks outstanding writes to the 16-entry, 16-bit register file (2 read ports, 1 write port, R0 hardwired zero).
- Sits between decode/issue and writeback; generates the issue stall for RAW hazards and write-count overflow.
- The RF writes on clock high and reads on clock low, so a writeback in cycle N is readable by an issue in the same cycle N. The scoreboard honours this same-cycle bypass.
- Also provides flush, an idle indication, error flagging and a stall-cycle counter for debug.

Parameters:
- NREG, 16, number of architectural registers; address width is log2(NREG)=4.
- CNT_W, 2, width of each per-register pending-write counter; max outstanding writes per register = 2^CNT_W-1 = 3.
- STALL_CNT_W, 16, width of the saturating stall-cycle debug counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- iss_vld  in  1  an instruction is presented for issue this cycle.
- iss_re0  in  1  instruction reads port 0.
- iss_re1  in  1  instruction reads port 1.
- iss_p0_addr  in  4  read address, port 0.
- iss_p1_addr  in  4  read address, port 1.
- iss_we  in  1  instruction will write a register.
- iss_dst_addr  in  4  destination register.
- wb_vld  in  1  writeback occurs this cycle (same as RF we).
- wb_dst_addr  in  4  writeback destination (same as RF dst_addr).
- flush  in  1  squash all in-flight writes.
- hlt  in  1  halt; freezes the debug counter.
- stall  out  1  combinational; issue must hold this cycle.
- iss_acc  out  1  combinational; iss_vld & ~stall.
- busy_vec  out  16  registered; bit r = pending count of r nonzero.
- idle  out  1  registered; no register pending.
- wb_err  out  1  sticky; writeback to a register with count 0.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (async, rst=1): all counters 0, busy_vec=0, idle=1, wb_err=0, stall_cycles=0. stall and iss_acc follow their equations (0 when iss_vld=0).
- R0: never counted. Issue to dst 0 and writeback to dst 0 are ignored. busy_vec[0] is always 0. Reads of R0 never stall.
- Effective busy per register r: eff[r] = (cnt[r] != 0) and not (wb_vld & wb_dst_addr==r & cnt[r]==1). This is the same-cycle WB→read bypass.
- stall = iss_vld & ~flush & ((iss_re0 & eff[p0]) | (iss_re1 & eff[p1]) | (iss_we & dst!=0 & cnt[dst]==MAX & ~(wb_vld & wb_dst==dst))).
- WAW is allowed. A register may have up to MAX in-flight writes; writebacks arrive in order.
- Counter update at posedge, per register r: +1 if iss_acc & iss_we & dst==r; −1 if wb_vld & wb_dst==r & cnt[r]!=0.
  - Both in the same cycle: net unchanged.
  - The counter never wraps in either direction.
- wb_vld to a register whose cnt==0 (dst!=0): counter stays 0; wb_err sets and stays set until reset.
- flush=1: forces stall=0 and iss_acc=0. On that edge all counters clear, overriding any issue or writeback that cycle. wb_err is not affected.
- busy_vec and idle reflect counters after the edge (latency 1 cycle from issue/WB). stall uses current counters (latency 0).
- stall_cycles: increments each posedge where stall=1 and hlt=0; saturates at all-ones; holds while hlt=1.
- Reset mid-operation: immediate clear; no pending state survives.

Decomposition:
- Shared package constants: NREG, REG_AW=4, DATA_W=16, the R0 index, and the CNT_W default. The RF and pipeline use the same ones.
- One sub-module, sb_cnt: a single saturating up/down counter with inc, dec, clr inputs and zero/max/one flags, instantiated NREG-1 times (R1..R15).
- Top level holds the stall equation, the error flag and the debug counter.

Test Plan:
- Reset, then issue we dst=3 → next cycle busy_vec=16'h0008, idle=0. Then issue re0 p0=3 → stall=1, stall_cycles increments. Then wb_vld dst=3 → in that same cycle stall=0, iss_acc=1; next cycle busy_vec=0, idle=1.
- Issue 3 writes to R5 with no WB → 4th issue with we dst=5 stalls. Assert wb_vld dst=5 in the same cycle → no stall, accepted, cnt[5] stays 3.
- Issue we dst=0 and read p0=0, p1=0 → never stall; busy_vec stays 0.
- Issue we dst=7 and wb_vld dst=7 in the same cycle with cnt[7]=1 → cnt stays 1, busy_vec[7]=1.
- wb_vld dst=9 with cnt[9]=0 → wb_err=1 and sticky; cnt[9]=0. Then flush with busy R2, R4 → next cycle busy_vec=0, idle=1, wb_err still 1.
- Hold stall 70000 cycles → stall_cycles=16'hFFFF. Assert hlt → count holds. Assert rst mid-sequence → all outputs return to reset values immediately.

Source files
------------

// File: rtl/rf_scoreboard_pkg.sv
// rf_scoreboard_pkg: shared register-file geometry and scoreboard widths.
package rf_scoreboard_pkg;
  localparam int NREG        = 16;
  localparam int REG_AW      = 4;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = 2;
  localparam int STALL_CNT_W = 16;
  localparam logic [REG_AW-1:0] R0 = '0;
endpackage

// File: rtl/rf_scoreboard_if.sv
// rf_scoreboard_if: issue/writeback/debug signals between pipeline and scoreboard.
interface rf_scoreboard_if;
  import rf_scoreboard_pkg::*;
  logic                   iss_vld;
  logic                   iss_re0;
  logic                   iss_re1;
  logic [REG_AW-1:0]      iss_p0_addr;
  logic [REG_AW-1:0]      iss_p1_addr;
  logic                   iss_we;
  logic [REG_AW-1:0]      iss_dst_addr;
  logic                   wb_vld;
  logic [REG_AW-1:0]      wb_dst_addr;
  logic                   flush;
  logic                   hlt;
  logic                   stall;
  logic                   iss_acc;
  logic [NREG-1:0]        busy_vec;
  logic                   idle;
  logic                   wb_err;
  logic [STALL_CNT_W-1:0] stall_cycles;
  modport master (
    output iss_vld, iss_re0, iss_re1, iss_p0_addr, iss_p1_addr, iss_we, iss_dst_addr,
           wb_vld, wb_dst_addr, flush, hlt,
    input  stall, iss_acc, busy_vec, idle, wb_err, stall_cycles
  );
  modport slave (
    input  iss_vld, iss_re0, iss_re1, iss_p0_addr, iss_p1_addr, iss_we, iss_dst_addr,
           wb_vld, wb_dst_addr, flush, hlt,
    output stall, iss_acc, busy_vec, idle, wb_err, stall_cycles
  );
endinterface

// File: rtl/rf_scoreboard_sb_cnt.sv
// sb_cnt: pending-write counter for one register; never wraps, simultaneous inc/dec cancel.
module sb_cnt #(
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_zero,
  output logic o_max,
  output logic o_one
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc & ~i_dec & ~o_max) r_cnt <= r_cnt + W'(1);
    else if (i_dec & ~i_inc & ~o_zero) r_cnt <= r_cnt - W'(1);
  assign o_zero = r_cnt == '0;
  assign o_max  = &r_cnt;
  assign o_one  = r_cnt == W'(1);
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: RAW/overflow issue stall with same-cycle writeback bypass, plus
// idle/busy status, sticky writeback error and a saturating stall-cycle counter.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  rf_scoreboard_if.slave  sb
);
  logic [NREG-1:0]        w_zero, w_max, w_one, w_eff;
  logic [NREG-1:1]        w_inc, w_dec;
  logic                   w_dst_full;
  logic                   r_wb_err;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  assign w_zero[R0] = 1'b1;
  assign w_max[R0]  = 1'b0;
  assign w_one[R0]  = 1'b0;
  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    assign w_inc[r] = sb.iss_acc & sb.iss_we & (sb.iss_dst_addr == REG_AW'(r));
    assign w_dec[r] = sb.wb_vld & (sb.wb_dst_addr == REG_AW'(r)) & ~w_zero[r];
    sb_cnt #(.W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_inc  (w_inc[r]),
      .i_dec  (w_dec[r]),
      .i_clr  (sb.flush),
      .o_zero (w_zero[r]),
      .o_max  (w_max[r]),
      .o_one  (w_one[r])
    );
  end
  // A register whose last pending write retires this cycle is already readable.
  always_comb begin
    w_eff = '0;
    for (int r = 0; r < NREG; r++)
      w_eff[r] = ~w_zero[r] & ~(sb.wb_vld & (sb.wb_dst_addr == REG_AW'(r)) & w_one[r]);
  end
  assign w_dst_full = sb.iss_we & (sb.iss_dst_addr != R0) & w_max[sb.iss_dst_addr]
                    & ~(sb.wb_vld & (sb.wb_dst_addr == sb.iss_dst_addr));
  assign sb.stall   = sb.iss_vld & ~sb.flush & ((sb.iss_re0 & w_eff[sb.iss_p0_addr])
                    | (sb.iss_re1 & w_eff[sb.iss_p1_addr]) | w_dst_full);
  assign sb.iss_acc = sb.iss_vld & ~sb.stall & ~sb.flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_wb_err <= 1'b0;
    else if (sb.wb_vld & (sb.wb_dst_addr != R0) & w_zero[sb.wb_dst_addr]) r_wb_err <= 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_stall_cycles <= '0;
    else if (sb.stall & ~sb.hlt & ~&r_stall_cycles) r_stall_cycles <= r_stall_cycles + 1'b1;
  assign sb.busy_vec     = ~w_zero;
  assign sb.idle         = &w_zero;
  assign sb.wb_err       = r_wb_err;
  assign sb.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed and random scenarios against a per-register count model.
module tb_rf_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_scoreboard_if sb_if ();
  rf_scoreboard dut (.clk(clk), .rst(rst), .sb(sb_if));

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int mcnt[16];
  bit merr;
  int msc;
  logic [15:0] q_busy[$];
  logic        q_err[$];
  int          q_sc[$];

  function automatic logic m_eff(input int r);
    return r != 0 && mcnt[r] != 0 &&
           !(sb_if.wb_vld && int'(sb_if.wb_dst_addr) == r && mcnt[r] == 1);
  endfunction

  function automatic logic m_stall();
    logic full;
    full = sb_if.iss_we && sb_if.iss_dst_addr != 0 && mcnt[sb_if.iss_dst_addr] == 3 &&
           !(sb_if.wb_vld && sb_if.wb_dst_addr == sb_if.iss_dst_addr);
    return sb_if.iss_vld && !sb_if.flush &&
           ((sb_if.iss_re0 && m_eff(int'(sb_if.iss_p0_addr))) ||
            (sb_if.iss_re1 && m_eff(int'(sb_if.iss_p1_addr))) || full);
  endfunction

  function automatic logic m_acc();
    return sb_if.iss_vld && !sb_if.flush && !m_stall();
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) mcnt[r] = 0;
    merr = 0;
    msc  = 0;
    q_busy.delete();
    q_err.delete();
    q_sc.delete();
  endtask

  task automatic drive(input logic vld, input logic re0, input logic [3:0] p0,
                       input logic re1, input logic [3:0] p1, input logic we,
                       input logic [3:0] dst, input logic wv, input logic [3:0] wd,
                       input logic fl, input logic h);
    sb_if.iss_vld = vld; sb_if.iss_re0 = re0; sb_if.iss_p0_addr = p0;
    sb_if.iss_re1 = re1; sb_if.iss_p1_addr = p1; sb_if.iss_we = we;
    sb_if.iss_dst_addr = dst; sb_if.wb_vld = wv; sb_if.wb_dst_addr = wd;
    sb_if.flush = fl; sb_if.hlt = h;
    #1;
  endtask

  // Advance the model through one edge, queue what the DUT should show afterwards.
  task automatic tick();
    logic s, a;
    logic [15:0] b;
    s = m_stall();
    a = m_acc();
    if (sb_if.wb_vld && sb_if.wb_dst_addr != 0 && mcnt[sb_if.wb_dst_addr] == 0) merr = 1;
    if (s && !sb_if.hlt && msc != 65535) msc++;
    for (int r = 1; r < 16; r++) begin
      int n;
      n = mcnt[r];
      if (a && sb_if.iss_we && int'(sb_if.iss_dst_addr) == r) n++;
      if (sb_if.wb_vld && int'(sb_if.wb_dst_addr) == r && mcnt[r] != 0) n--;
      if (n > 3) n = 3;
      mcnt[r] = sb_if.flush ? 0 : n;
    end
    b = '0;
    for (int r = 0; r < 16; r++) b[r] = mcnt[r] != 0;
    q_busy.push_back(b);
    q_err.push_back(merr);
    q_sc.push_back(msc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    chk_cnt++; if (sb_if.busy_vec !== 16'h0) $display("FAIL reset_busy got %h exp 0000", sb_if.busy_vec); else pass_cnt++;
    chk_cnt++; if (sb_if.idle !== 1'b1) $display("FAIL reset_idle got %b exp 1", sb_if.idle); else pass_cnt++;
    chk_cnt++; if (sb_if.wb_err !== 1'b0) $display("FAIL reset_err got %b exp 0", sb_if.wb_err); else pass_cnt++;
    chk_cnt++; if (sb_if.stall_cycles !== 16'h0) $display("FAIL reset_sc got %h exp 0000", sb_if.stall_cycles); else pass_cnt++;
    chk_cnt++; if (sb_if.stall !== 1'b0 || sb_if.iss_acc !== 1'b0) $display("FAIL reset_stall got %b%b exp 00", sb_if.stall, sb_if.iss_acc); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw();
    logic [15:0] eb;
    int es;
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    chk_cnt++; if (sb_if.iss_acc !== 1'b1 || sb_if.stall !== 1'b0) $display("FAIL raw_issue acc/stall got %b/%b exp 1/0", sb_if.iss_acc, sb_if.stall); else pass_cnt++;
    tick();
    eb = q_busy.pop_front(); void'(q_err.pop_front()); void'(q_sc.pop_front());
    chk_cnt++; if (sb_if.busy_vec !== 16'h0008 || eb !== 16'h0008) $display("FAIL raw_busy got %h exp 0008", sb_if.busy_vec); else pass_cnt++;
    chk_cnt++; if (sb_if.idle !== 1'b0) $display("FAIL raw_idle got %b exp 0", sb_if.idle); else pass_cnt++;
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_cnt++; if (sb_if.stall !== 1'b1 || sb_if.iss_acc !== 1'b0) $display("FAIL raw_stall got %b/%b exp 1/0", sb_if.stall, sb_if.iss_acc); else pass_cnt++;
    tick();
    void'(q_busy.pop_front()); void'(q_err.pop_front()); es = q_sc.pop_front();
    chk_cnt++; if (sb_if.stall_cycles !== 16'(es) || es != 1) $display("FAIL raw_sc got %0d exp 1", sb_if.stall_cycles); else pass_cnt++;
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    void'(q_busy.pop_front()); void'(q_err.pop_front()); es = q_sc.pop_front();
    chk_cnt++; if (sb_if.stall_cycles !== 16'(es) || es != 1) $display("FAIL raw_hlt_sc got %0d exp 1", sb_if.stall_cycles); else pass_cnt++;
    drive(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0);
    chk_cnt++; if (sb_if.stall !== 1'b0 || sb_if.iss_acc !== 1'b1) $display("FAIL raw_bypass got %b/%b exp 0/1", sb_if.stall, sb_if.iss_acc); else pass_cnt++;
    tick();
    eb = q_busy.pop_front(); void'(q_err.pop_front()); void'(q_sc.pop_front());
    chk_cnt++; if (sb_if.busy_vec !== eb || sb_if.idle !== 1'b1) $display("FAIL raw_retire busy/idle got %h/%b exp %h/1", sb_if.busy_vec, sb_if.idle, eb); else pass_cnt++;
  endtask

  task automatic test_waw_max();
    logic [15:0] eb;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      tick();
    end
    q_busy.delete(); q_err.delete(); q_sc.delete();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    chk_cnt++; if (sb_if.stall !== 1'b1) $display("FAIL waw_full_stall got %b exp 1", sb_if.stall); else pass_cnt++;
    drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0);
    chk_cnt++; if (sb_if.stall !== 1'b0 || sb_if.iss_acc !== 1'b1) $display("FAIL waw_wb_accept got %b/%b exp 0/1", sb_if.stall, sb_if.iss_acc); else pass_cnt++;
    tick();
    void'(q_busy.pop_front()); void'(q_err.pop_front()); void'(q_sc.pop_front());
    // Count must still be 3: one more issue without WB must stall.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    chk_cnt++; if (sb_if.stall !== 1'b1) $display("FAIL waw_still_full got %b exp 1", sb_if.stall); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
      tick();
    end
    repeat (2) begin void'(q_busy.pop_front()); void'(q_err.pop_front()); void'(q_sc.pop_front()); end
    eb = q_busy.pop_front(); void'(q_err.pop_front()); void'(q_sc.pop_front());
    chk_cnt++; if (sb_if.busy_vec !== 16'h0 || eb !== 16'h0 || sb_if.wb_err !== 1'b0) $display("FAIL waw_drain busy/err got %h/%b exp 0000/0", sb_if.busy_vec, sb_if.wb_err); else pass_cnt++;
  endtask

  task automatic test_r0();
    drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk_cnt++; if (sb_if.stall !== 1'b0 || sb_if.iss_acc !== 1'b1) $display("FAIL r0_stall got %b/%b exp 0/1", sb_if.stall, sb_if.iss_acc); else pass_cnt++;
    tick();
    drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    tick();
    void'(q_busy.pop_front()); void'(q_err.pop_front()); void'(q_sc.pop_front());
    void'(q_busy.pop_front()); void'(q_err.pop_front()); void'(q_sc.pop_front());
    chk_cnt++; if (sb_if.busy_vec !== 16'h0 || sb_if.idle !== 1'b1 || sb_if.wb_err !== 1'b0) $display("FAIL r0_state busy/idle/err got %h/%b/%b exp 0000/1/0", sb_if.busy_vec, sb_if.idle, sb_if.wb_err); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic [15:0] eb;
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0);
    tick();
    void'(q_busy.pop_front()); void'(q_err.pop_front()); void'(q_sc.pop_front());
    eb = q_busy.pop_front(); void'(q_err.pop_front()); void'(q_sc.pop_front());
    chk_cnt++; if (sb_if.busy_vec !== eb || sb_if.busy_vec !== 16'h0080) $display("FAIL same_busy got %h exp 0080", sb_if.busy_vec); else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    eb = q_busy.pop_front(); void'(q_err.pop_front()); void'(q_sc.pop_front());
    chk_cnt++; if (sb_if.busy_vec !== eb || sb_if.idle !== 1'b1) $display("FAIL same_drain got %h/%b exp %h/1", sb_if.busy_vec, sb_if.idle, eb); else pass_cnt++;
  endtask

  task automatic test_err_flush();
    logic [15:0] eb;
    logic ee;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    tick();
    eb = q_busy.pop_front(); ee = q_err.pop_front(); void'(q_sc.pop_front());
    chk_cnt++; if (sb_if.wb_err !== ee || ee !== 1'b1 || sb_if.busy_vec !== eb) $display("FAIL err_set err/busy got %b/%h exp 1/%h", sb_if.wb_err, sb_if.busy_vec, eb); else pass_cnt++;
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    tick();
    repeat (2) begin void'(q_busy.pop_front()); void'(q_err.pop_front()); void'(q_sc.pop_front()); end
    chk_cnt++; if (sb_if.wb_err !== 1'b1 || sb_if.busy_vec !== 16'h0014) $display("FAIL err_sticky err/busy got %b/%h exp 1/0014", sb_if.wb_err, sb_if.busy_vec); else pass_cnt++;
    drive(1, 1, 2, 1, 4, 1, 6, 0, 0, 1, 0);
    chk_cnt++; if (sb_if.stall !== 1'b0 || sb_if.iss_acc !== 1'b0) $display("FAIL flush_comb got %b/%b exp 0/0", sb_if.stall, sb_if.iss_acc); else pass_cnt++;
    tick();
    eb = q_busy.pop_front(); ee = q_err.pop_front(); void'(q_sc.pop_front());
    chk_cnt++; if (sb_if.busy_vec !== 16'h0 || eb !== 16'h0 || sb_if.idle !== 1'b1 || sb_if.wb_err !== ee) $display("FAIL flush_state busy/idle/err got %h/%b/%b exp 0000/1/1", sb_if.busy_vec, sb_if.idle, sb_if.wb_err); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] eb;
    logic ee, xs, xa;
    int es;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0));
      xs = m_stall();
      xa = m_acc();
      chk_cnt++; if (sb_if.stall !== xs || sb_if.iss_acc !== xa) $display("FAIL rnd_comb[%0d] stall/acc got %b/%b exp %b/%b", i, sb_if.stall, sb_if.iss_acc, xs, xa); else pass_cnt++;
      tick();
      eb = q_busy.pop_front(); ee = q_err.pop_front(); es = q_sc.pop_front();
      chk_cnt++; if (sb_if.busy_vec !== eb || sb_if.idle !== (eb == 16'h0) || sb_if.wb_err !== ee || sb_if.stall_cycles !== 16'(es))
        $display("FAIL rnd_state[%0d] busy/idle/err/sc got %h/%b/%b/%0d exp %h/%b/%b/%0d", i, sb_if.busy_vec, sb_if.idle, sb_if.wb_err, sb_if.stall_cycles, eb, (eb == 16'h0), ee, es);
      else pass_cnt++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    q_busy.delete(); q_err.delete(); q_sc.delete();
  endtask

  task automatic test_saturate_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65600; i++) tick();
    q_busy.delete(); q_err.delete(); q_sc.delete();
    chk_cnt++; if (sb_if.stall_cycles !== 16'hFFFF || msc != 65535) $display("FAIL sat_sc got %h exp ffff", sb_if.stall_cycles); else pass_cnt++;
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    chk_cnt++; if (sb_if.stall_cycles !== 16'hFFFF) $display("FAIL sat_hlt_sc got %h exp ffff", sb_if.stall_cycles); else pass_cnt++;
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_cnt++; if (sb_if.busy_vec !== 16'h0 || sb_if.idle !== 1'b1 || sb_if.wb_err !== 1'b0 || sb_if.stall_cycles !== 16'h0)
      $display("FAIL midrst busy/idle/err/sc got %h/%b/%b/%h exp 0000/1/0/0000", sb_if.busy_vec, sb_if.idle, sb_if.wb_err, sb_if.stall_cycles);
    else pass_cnt++;
    chk_cnt++; if (sb_if.stall !== 1'b0 || sb_if.iss_acc !== 1'b1) $display("FAIL midrst_stall got %b/%b exp 0/1", sb_if.stall, sb_if.iss_acc); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw_max();
    test_r0();
    test_same_cycle();
    test_err_flush();
    test_back_to_back();
    test_saturate_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
